// File: rtl/gpu_tile_row_fetcher.sv
// -----------------------------------------------------------------------------
// gpu_tile_row_fetcher
//
// Background tile-row fetcher. A request names a nametable entry (tile index)
// and a pixel row inside that tile. The block reads the nametable entry from
// VRAM, then reads one pattern byte per bitplane for the addressed row. It
// applies vertical flip by remapping the row and horizontal flip by
// bit-reversing each byte. The plane bytes are then held on a valid/ready
// output until the consumer takes them.
//
// Only one VRAM read is ever outstanding. Each read is a one-cycle strobe
// followed by MemLatency wait cycles, and the data is captured in the last
// wait cycle.
//
// Ports
//   clk              GPU clock, rising edge
//   rst_n            asynchronous active-low reset
//   req_valid        request present
//   req_ready        high only while idle
//   req_tile_idx     nametable entry index
//   req_row          pixel row within the tile, before flip
//   vram_rd_en       one-cycle VRAM read strobe
//   vram_addr        read address, meaningful while vram_rd_en is high
//   vram_rd_data     read data, valid MemLatency cycles after the strobe
//   out_valid        fetched row available
//   out_ready        consumer accepts the row
//   out_planes       plane p in bits [8p+7:8p]; bit 7 is the leftmost pixel
//   out_colorselect  colorselect bit from the nametable entry
// -----------------------------------------------------------------------------
module gpu_tile_row_fetcher #(
    parameter int          NumPlanes  = 2,
    parameter int          TileRows   = 8,
    parameter int          MemLatency = 1,
    parameter logic [11:0] NtblBase   = 12'h800,
    parameter logic [11:0] PmbBase    = 12'h000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [9:0]                    req_tile_idx,
    input  logic [$clog2(TileRows)-1:0]   req_row,
    output logic                          vram_rd_en,
    output logic [11:0]                   vram_addr,
    input  logic [7:0]                    vram_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [8*NumPlanes-1:0]        out_planes,
    output logic                          out_colorselect
);

    localparam int RowW = $clog2(TileRows);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] NT_ISSUE = 3'd1;
    localparam logic [2:0] NT_WAIT  = 3'd2;
    localparam logic [2:0] PT_ISSUE = 3'd3;
    localparam logic [2:0] PT_WAIT  = 3'd4;
    localparam logic [2:0] OUT      = 3'd5;

    localparam logic [1:0]      WaitLast    = 2'(MemLatency - 1);
    localparam logic [1:0]      LastPlane   = 2'(NumPlanes - 1);
    localparam logic [RowW-1:0] RowMax      = RowW'(TileRows - 1);
    localparam logic [11:0]     PlaneStride = 12'(TileRows);
    localparam logic [11:0]     TileStride  = 12'(TileRows * NumPlanes);

    logic [2:0]             state;
    logic [9:0]             tile_idx;
    logic [RowW-1:0]        row;
    logic [1:0]             wait_cnt;
    logic [1:0]             plane_idx;
    logic                   colorselect;
    logic                   hflip;
    logic                   vflip;
    logic [4:0]             pmba;
    logic [8*NumPlanes-1:0] planes;

    logic [RowW-1:0]        row_eff;
    logic [11:0]            nt_addr;
    logic [11:0]            pt_addr;
    logic                   wait_done;

    function automatic logic [7:0] bit_reverse(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

    // The flip bits are already latched by the time any pattern read is
    // issued, so the row remap can be purely combinational.
    assign row_eff   = vflip ? (RowMax - row) : row;
    assign nt_addr   = NtblBase + {2'b00, tile_idx};
    assign pt_addr   = PmbBase
                     + ({7'b0, pmba} * TileStride)
                     + ({10'b0, plane_idx} * PlaneStride)
                     + {{(12 - RowW){1'b0}}, row_eff};
    assign wait_done = (wait_cnt == WaitLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tile_idx    <= '0;
            row         <= '0;
            wait_cnt    <= '0;
            plane_idx   <= '0;
            colorselect <= 1'b0;
            hflip       <= 1'b0;
            vflip       <= 1'b0;
            pmba        <= '0;
            planes      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tile_idx <= req_tile_idx;
                        row      <= req_row;
                        state    <= NT_ISSUE;
                    end
                end
                NT_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= NT_WAIT;
                end
                NT_WAIT: begin
                    if (wait_done) begin
                        {colorselect, hflip, vflip, pmba} <= vram_rd_data;
                        plane_idx <= '0;
                        state     <= PT_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                PT_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= PT_WAIT;
                end
                PT_WAIT: begin
                    if (wait_done) begin
                        // Constant-index loop keeps every plane select in range
                        // regardless of NumPlanes.
                        for (int p = 0; p < NumPlanes; p++) begin
                            if (plane_idx == 2'(p)) begin
                                planes[8*p +: 8] <= hflip ? bit_reverse(vram_rd_data)
                                                          : vram_rd_data;
                            end
                        end
                        if (plane_idx == LastPlane) begin
                            state <= OUT;
                        end else begin
                            plane_idx <= plane_idx + 2'd1;
                            state     <= PT_ISSUE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobe and address are decoded from state so that they drop to zero
    // the instant reset asserts.
    always_comb begin
        vram_rd_en = 1'b0;
        vram_addr  = '0;
        case (state)
            NT_ISSUE: begin
                vram_rd_en = 1'b1;
                vram_addr  = nt_addr;
            end
            PT_ISSUE: begin
                vram_rd_en = 1'b1;
                vram_addr  = pt_addr;
            end
            default: begin
                vram_rd_en = 1'b0;
                vram_addr  = '0;
            end
        endcase
    end

    assign req_ready       = (state == IDLE);
    assign out_valid       = (state == OUT);
    assign out_planes      = planes;
    assign out_colorselect = colorselect;

endmodule

// File: tb/tb_gpu_tile_row_fetcher.sv
// -----------------------------------------------------------------------------
// Bench for gpu_tile_row_fetcher. There are two instances:
//   A: default parameters (2 planes, latency 1, nametable at 0x800)
//   B: 4 planes, latency 3, nametable at 0xC00, pattern base at 0x100
// Both instances share one VRAM image. Each instance has its own read
// pipeline, and that pipeline returns random junk outside the valid data cycle.
// -----------------------------------------------------------------------------
module tb_gpu_tile_row_fetcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_req_valid, a_req_ready, a_rd_en, a_out_valid, a_out_ready, a_cs;
    logic [9:0]  a_tile;
    logic [2:0]  a_row;
    logic [11:0] a_addr;
    logic [7:0]  a_rd_data;
    logic [15:0] a_planes;

    logic        b_req_valid, b_req_ready, b_rd_en, b_out_valid, b_out_ready, b_cs;
    logic [9:0]  b_tile;
    logic [2:0]  b_row;
    logic [11:0] b_addr;
    logic [7:0]  b_rd_data;
    logic [31:0] b_planes;

    logic [7:0] mem [4096];

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    gpu_tile_row_fetcher dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_tile_idx(a_tile), .req_row(a_row),
        .vram_rd_en(a_rd_en), .vram_addr(a_addr), .vram_rd_data(a_rd_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_planes(a_planes), .out_colorselect(a_cs)
    );

    gpu_tile_row_fetcher #(
        .NumPlanes(4), .TileRows(8), .MemLatency(3),
        .NtblBase(12'hC00), .PmbBase(12'h100)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_tile_idx(b_tile), .req_row(b_row),
        .vram_rd_en(b_rd_en), .vram_addr(b_addr), .vram_rd_data(b_rd_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_planes(b_planes), .out_colorselect(b_cs)
    );

    // VRAM models: data appears exactly MemLatency cycles after the strobe.
    always @(posedge clk) a_rd_data <= a_rd_en ? mem[a_addr] : 8'($urandom);

    logic        b_v0 = 1'b0, b_v1 = 1'b0;
    logic [11:0] b_a0 = '0,   b_a1 = '0;
    always @(posedge clk) begin
        b_v0      <= b_rd_en;
        b_a0      <= b_addr;
        b_v1      <= b_v0;
        b_a1      <= b_a0;
        b_rd_data <= b_v1 ? mem[b_a1] : 8'($urandom);
    end

    // Strobe monitors
    logic [11:0] a_q[$], b_q[$];
    int          a_t[$], b_t[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (a_rd_en === 1'b1) begin a_q.push_back(a_addr); a_t.push_back(cyc); end
    always @(posedge clk) if (b_rd_en === 1'b1) begin b_q.push_back(b_addr); b_t.push_back(cyc); end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: read the entry, remap the row, walk the planes.
    function automatic void model(input bit which, input int tile, input int row,
                                  output logic [11:0] addrs[5], output logic [31:0] planes,
                                  output logic cs);
        int np = which ? 4 : 2;
        int nb = which ? 'hC00 : 'h800;
        int pb = which ? 'h100 : 0;
        logic [7:0] ent, b, rb;
        int pmba, re, a;
        for (int i = 0; i < 5; i++) addrs[i] = '0;
        planes   = '0;
        a        = (nb + tile) % 4096;
        addrs[0] = 12'(a);
        ent      = mem[a];
        cs       = ent[7];
        pmba     = int'(ent[4:0]);
        re       = ent[5] ? (7 - row) : row;
        for (int p = 0; p < np; p++) begin
            a          = (pb + pmba * 8 * np + p * 8 + re) % 4096;
            addrs[p+1] = 12'(a);
            b          = mem[a];
            for (int k = 0; k < 8; k++) rb[k] = b[7-k];
            planes[8*p +: 8] = ent[6] ? rb : b;
        end
    endfunction

    task automatic fetch(input bit which, input int tile, input int row, input int hold);
        logic [11:0] ea[5];
        logic [31:0] ep;
        logic        ecs;
        int np, ml, lat, nstb;
        model(which, tile, row, ea, ep, ecs);
        np = which ? 4 : 2;
        ml = which ? 3 : 1;
        @(negedge clk);
        if (which) begin
            b_q.delete(); b_t.delete();
            b_req_valid = 1'b1; b_tile = 10'(tile); b_row = 3'(row); b_out_ready = 1'b0;
        end else begin
            a_q.delete(); a_t.delete();
            a_req_valid = 1'b1; a_tile = 10'(tile); a_row = 3'(row); a_out_ready = 1'b0;
        end
        chk("req_ready_idle", which ? b_req_ready : a_req_ready, 1);
        @(posedge clk); #1;
        // Scramble request fields while busy; they must be ignored.
        if (which) begin b_req_valid = 1'b0; b_tile = 10'($urandom); b_row = 3'($urandom); end
        else       begin a_req_valid = 1'b0; a_tile = 10'($urandom); a_row = 3'($urandom); end
        lat = 0;
        while ((which ? b_out_valid : a_out_valid) !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, (np + 1) * (ml + 1));
        nstb = which ? b_q.size() : a_q.size();
        chk("strobe_count", nstb, np + 1);
        for (int i = 0; i <= np && i < nstb; i++) begin
            chk("strobe_addr", which ? b_q[i] : a_q[i], ea[i]);
            if (i > 0) chk("strobe_spacing", which ? (b_t[i] - b_t[i-1]) : (a_t[i] - a_t[i-1]), ml + 1);
        end
        chk("planes", which ? b_planes : {16'b0, a_planes}, ep);
        chk("colorselect", which ? b_cs : a_cs, ecs);
        chk("req_ready_busy", which ? b_req_ready : a_req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", which ? b_out_valid : a_out_valid, 1);
            chk("hold_planes", which ? b_planes : {16'b0, a_planes}, ep);
            chk("hold_req_ready", which ? b_req_ready : a_req_ready, 0);
        end
        if (hold > 0) chk("hold_no_strobe", which ? b_q.size() : a_q.size(), np + 1);
        if (which) b_out_ready = 1'b1; else a_out_ready = 1'b1;
        @(posedge clk); #1;
        if (which) b_out_ready = 1'b0; else a_out_ready = 1'b0;
        chk("post_valid", which ? b_out_valid : a_out_valid, 0);
        chk("post_req_ready", which ? b_req_ready : a_req_ready, 1);
        chk("post_planes_hold", which ? b_planes : {16'b0, a_planes}, ep);
    endtask

    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_tile = '0; a_row = '0; a_out_ready = 1'b0;
        b_req_valid = 1'b0; b_tile = '0; b_row = '0; b_out_ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        #1;
        chk("rst_req_ready", a_req_ready, 1);
        chk("rst_rd_en", a_rd_en, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_planes", a_planes, 0);
        chk("rst_cs", a_cs, 0);
        chk("rst_b_planes", b_planes, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Plain entry, no flip
        mem[12'h805] = 8'h83;
        for (int i = 0; i < 16; i++) mem[12'h030 + i] = 8'(8'h30 + i);
        fetch(0, 5, 2, 0);
        chk("t1_planes", a_planes, 16'h3A32);
        chk("t1_cs", a_cs, 1);
        if (a_q.size() == 3) begin
            chk("t1_nt_addr", a_q[0], 12'h805);
            chk("t1_p0_addr", a_q[1], 12'h032);
            chk("t1_p1_addr", a_q[2], 12'h03A);
        end else chk("t1_strobes", a_q.size(), 3);

        // Both flips
        mem[12'h807] = 8'h61;
        mem[12'h015] = 8'h01;
        mem[12'h01D] = 8'hF0;
        fetch(0, 7, 2, 0);
        chk("t2_planes", a_planes, 16'h0F80);
        chk("t2_cs", a_cs, 0);

        // Backpressure
        fetch(0, 5, 2, 10);

        // Reset in the middle of the first pattern read
        @(negedge clk);
        a_req_valid = 1'b1; a_tile = 10'd7; a_row = 3'd2;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", a_req_ready, 1);
        chk("mid_rst_rd_en", a_rd_en, 0);
        chk("mid_rst_addr", a_addr, 0);
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_planes", a_planes, 0);
        chk("mid_rst_cs", a_cs, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_q.delete(); a_t.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_strobes", a_q.size(), 0);
        chk("post_rst_planes", a_planes, 0);
        fetch(0, 5, 3, 0);

        // Randomized traffic on the default instance
        for (int n = 0; n < 20; n++) fetch(0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

        // Wide, slow instance with boundary tiles
        fetch(1, 959, 4, 0);
        if (b_q.size() > 0) chk("t6_addr_959", b_q[0], 12'hFBF);
        fetch(1, 1023, 0, 2);
        if (b_q.size() > 0) chk("t6_addr_1023", b_q[0], 12'hFFF);
        for (int n = 0; n < 8; n++) fetch(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
